breath_color_scheduler: RTL and testbench

Sequencer for the RGB breathing-LED datapath. It owns one shared PWM generator and steps it through ramp-up, hold-high, ramp-down and hold-low phases. At each dark point it chooses the next colour: either from two requesters, arbitrated round-robin, or from an internal R→G→B rotation when nobody is requesting. It sits between the board's active-low RGB LED pins and any block that wants to show a colour, such as key handlers or status logic.

---
 rtl/breath_color_scheduler_if.sv | 9 +
 rtl/breath_color_scheduler.sv | 154 +++++++++++++++
 tb/tb_breath_color_scheduler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/breath_color_scheduler_if.sv
// rtl/breath_color_scheduler_if.sv - colour request/grant bundle between requesters and the breath scheduler
interface breath_color_scheduler_if;
   logic [1:0] req;
   logic [5:0] req_color;
   logic [1:0] gnt;

   modport master (output req, output req_color, input gnt);
   modport slave  (input req, input req_color, output gnt);
endinterface

// File: rtl/breath_color_scheduler.sv
// rtl/breath_color_scheduler.sv - breathing RGB LED sequencer: shared PWM, ramp/hold phases,
// round-robin colour requests with an R->G->B fallback rotation
module breath_color_scheduler #(
   parameter int PERIOD = 10000,
   parameter int STEP   = 40,
   parameter int HOLD   = 25,
   parameter int CW     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   breath_color_scheduler_if.slave       bus,
   output logic                          led_r,
   output logic                          led_g,
   output logic                          led_b,
   output logic [1:0]                    phase,
   output logic                          cycle_done
);

   typedef enum logic [1:0] {
      ST_UP      = 2'b00,
      ST_HOLD_HI = 2'b01,
      ST_DOWN    = 2'b10,
      ST_HOLD_LO = 2'b11
   } state_t;

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   localparam logic [CW-1:0] PERIOD_C  = CW'(PERIOD);
   localparam logic [CW-1:0] STEP_C    = CW'(STEP);
   localparam logic [CW-1:0] FCNT_LAST = CW'(PERIOD - 1);
   // Saturating when duty >= PERIOD-STEP is the same as duty+STEP >= PERIOD without the overflowing add
   localparam logic [CW-1:0] UP_LIM    = CW'(PERIOD - STEP);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] fcnt_q, fcnt_d;
   logic [CW-1:0] duty_q, duty_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [2:0]    color_q, color_d;
   logic [2:0]    rot_q, rot_d;
   logic          ptr_q, ptr_d;
   logic [1:0]    gnt_q, gnt_d;
   logic          cdone_q, cdone_d;
   logic [2:0]    led_q, led_d;
   logic          frame_end;
   logic          win;
   logic [2:0]    lit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_UP;
         fcnt_q  <= '0;
         duty_q  <= '0;
         hold_q  <= '0;
         color_q <= 3'b001;
         rot_q   <= 3'b001;
         ptr_q   <= 1'b1;
         gnt_q   <= 2'b00;
         cdone_q <= 1'b0;
         led_q   <= 3'b111;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         duty_q  <= duty_d;
         hold_q  <= hold_d;
         color_q <= color_d;
         rot_q   <= rot_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         cdone_q <= cdone_d;
         led_q   <= led_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      fcnt_d    = fcnt_q;
      duty_d    = duty_q;
      hold_d    = hold_q;
      color_d   = color_q;
      rot_d     = rot_q;
      ptr_d     = ptr_q;
      gnt_d     = 2'b00;
      cdone_d   = 1'b0;
      win       = 1'b0;
      frame_end = en && (fcnt_q == FCNT_LAST);

      if (en) begin
         fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
      end

      if (frame_end) begin
         case (state_q)
            ST_UP: begin
               if (duty_q >= UP_LIM) begin
                  duty_d  = PERIOD_C;
                  hold_d  = '0;
                  state_d = ST_HOLD_HI;
               end else begin
                  duty_d = duty_q + STEP_C;
               end
            end
            ST_HOLD_HI: begin
               if (hold_q == HOLD_LAST) begin
                  hold_d  = '0;
                  state_d = ST_DOWN;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            ST_DOWN: begin
               if (duty_q <= STEP_C) begin
                  duty_d  = '0;
                  hold_d  = '0;
                  state_d = ST_HOLD_LO;
               end else begin
                  duty_d = duty_q - STEP_C;
               end
            end
            default: begin
               if (hold_q == HOLD_LAST) begin
                  hold_d  = '0;
                  state_d = ST_UP;
                  cdone_d = 1'b1;
                  if (|bus.req) begin
                     // ptr_q remembers the last winner, so a tie goes to the other requester
                     win     = (bus.req == 2'b11) ? ~ptr_q : bus.req[1];
                     gnt_d   = win ? 2'b10 : 2'b01;
                     color_d = win ? bus.req_color[5:3] : bus.req_color[2:0];
                     ptr_d   = win;
                  end else begin
                     rot_d   = {rot_q[1:0], rot_q[2]};
                     color_d = {rot_q[1:0], rot_q[2]};
                  end
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         endcase
      end

      lit   = color_q & {3{fcnt_q < duty_q}};
      led_d = en ? ~lit : 3'b111;
   end

   assign bus.gnt    = gnt_q;
   assign cycle_done = cdone_q;
   assign phase      = state_q;
   assign led_r      = led_q[0];
   assign led_g      = led_q[1];
   assign led_b      = led_q[2];

endmodule

// File: tb/tb_breath_color_scheduler.sv
// tb/tb_breath_color_scheduler.sv - directed bench: small-parameter breath timing, rotation,
// arbitration, pause, async reset and saturation
module tb_breath_color_scheduler;
   logic       clk;
   logic       rst;
   logic       en;
   logic       led_r1, led_g1, led_b1, cd1;
   logic [1:0] ph1;
   logic       led_r2, led_g2, led_b2, cd2;
   logic [1:0] ph2;

   int n_chk = 0;
   int n_bad = 0;

   breath_color_scheduler_if bif1 ();
   breath_color_scheduler_if bif2 ();

   breath_color_scheduler #(.PERIOD(10), .STEP(2), .HOLD(2), .CW(8)) dut1 (
      .clk(clk), .rst(rst), .en(en), .bus(bif1.slave),
      .led_r(led_r1), .led_g(led_g1), .led_b(led_b1), .phase(ph1), .cycle_done(cd1));

   breath_color_scheduler #(.PERIOD(10), .STEP(3), .HOLD(2), .CW(8)) dut2 (
      .clk(clk), .rst(rst), .en(en), .bus(bif2.slave),
      .led_r(led_r2), .led_g(led_g2), .led_b(led_b2), .phase(ph2), .cycle_done(cd2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      en  = 1'b1;
      step();
      step();
      rst = 1'b1;
   endtask

   int lows1[14];
   int lows2[12];
   int mask[4];
   int exp1[14] = '{0, 2, 4, 6, 8, 10, 10, 10, 8, 6, 4, 2, 0, 0};
   int exp2[12] = '{0, 3, 6, 9, 10, 10, 10, 7, 4, 1, 0, 0};
   int expm[4]  = '{1, 2, 4, 1};
   int cd_cnt, gnt_cnt, cnt, bad_pause;

   initial begin
      rst = 1'b0;
      en  = 1'b1;
      bif1.req = 2'b00;
      bif1.req_color = 6'b000000;
      bif2.req = 2'b00;
      bif2.req_color = 6'b000000;

      // reset state
      step();
      step();
      chk("rst_leds", {led_b1, led_g1, led_r1}, 3'b111);
      chk("rst_phase", ph1, 2'b00);
      chk("rst_gnt", bif1.gnt, 2'b00);
      chk("rst_cd", cd1, 1'b0);
      rst = 1'b1;

      // first frames, auto rotation, saturation on dut2
      foreach (lows1[i]) lows1[i] = 0;
      foreach (lows2[i]) lows2[i] = 0;
      foreach (mask[i]) mask[i] = 0;
      cd_cnt = 0;
      gnt_cnt = 0;
      for (int k = 1; k <= 560; k++) begin
         int c;
         step();
         c = k - 1;
         if (c < 140 && !led_r1) lows1[c / 10]++;
         if (c < 120 && !led_r2) lows2[c / 10]++;
         mask[c / 140] |= {29'd0, ~led_b1, ~led_g1, ~led_r1};
         if (bif1.gnt != 2'b00) gnt_cnt++;
         if (cd1) begin
            cd_cnt++;
            chk("rot_cd_pos", k % 140, 0);
         end
         if (k == 49) chk("ph1_up", ph1, 2'b00);
         if (k == 50) chk("ph1_hold_hi", ph1, 2'b01);
         if (k == 39) chk("ph2_up", ph2, 2'b00);
         if (k == 40) chk("ph2_hold_hi", ph2, 2'b01);
         if (k == 70) chk("ph1_down", ph1, 2'b10);
         if (k == 120) chk("ph1_hold_lo", ph1, 2'b11);
      end
      foreach (exp1[i]) chk($sformatf("duty1_f%0d", i), lows1[i], exp1[i]);
      foreach (exp2[i]) chk($sformatf("sat2_f%0d", i), lows2[i], exp2[i]);
      foreach (expm[i]) chk($sformatf("rot_color_b%0d", i), mask[i], expm[i]);
      chk("rot_cd_count", cd_cnt, 4);
      chk("rot_no_gnt", gnt_cnt, 0);

      // arbitration
      bif1.req = 2'b11;
      bif1.req_color = 6'b100_010;
      do_reset();
      foreach (mask[i]) mask[i] = 0;
      gnt_cnt = 0;
      for (int k = 1; k <= 420; k++) begin
         step();
         mask[(k - 1) / 140] |= {29'd0, ~led_b1, ~led_g1, ~led_r1};
         if (bif1.gnt != 2'b00) gnt_cnt++;
         if (k == 140) begin
            chk("arb_gnt0", bif1.gnt, 2'b01);
            chk("arb_cd0", cd1, 1'b1);
            bif1.req = 2'b10;
         end
         if (k == 141) chk("arb_gnt_pulse", bif1.gnt, 2'b00);
         if (k == 280) chk("arb_gnt1", bif1.gnt, 2'b10);
         if (k == 420) chk("arb_gnt2", bif1.gnt, 2'b10);
      end
      chk("arb_color0", mask[0], 1);
      chk("arb_color1", mask[1], 2);
      chk("arb_color2", mask[2], 4);
      chk("arb_gnt_count", gnt_cnt, 3);

      // pause mid-UP for 37 cycles
      bif1.req = 2'b00;
      do_reset();
      cnt = 0;
      cd_cnt = 0;
      bad_pause = 0;
      for (int k = 1; k <= 180; k++) begin
         step();
         if (k <= 177 && !led_r1) cnt++;
         if (k >= 26 && k <= 62 && ({led_b1, led_g1, led_r1} != 3'b111 || ph1 != 2'b00 || cd1))
            bad_pause++;
         if (cd1) cd_cnt++;
         if (k == 140) chk("pause_no_early_cd", cd1, 1'b0);
         if (k == 177) chk("pause_cd_late", cd1, 1'b1);
         if (k == 25) en = 1'b0;
         if (k == 62) en = 1'b1;
      end
      chk("pause_blank", bad_pause, 0);
      chk("pause_lit_total", cnt, 70);
      chk("pause_cd_count", cd_cnt, 1);

      // async reset mid-DOWN
      do_reset();
      for (int k = 1; k <= 75; k++) step();
      chk("ar_pre_phase", ph1, 2'b10);
      chk("ar_pre_led", led_r1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_leds", {led_b1, led_g1, led_r1}, 3'b111);
      chk("ar_phase", ph1, 2'b00);
      step();
      chk("ar_gnt", bif1.gnt, 2'b00);
      chk("ar_cd", cd1, 1'b0);
      rst = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (!led_r1) cnt++;
         if (k == 11) chk("ar_restart_f1", led_r1, 1'b0);
      end
      chk("ar_restart_lows", cnt, 2);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
